// File: rtl/layers_pkg.sv
// layers_pkg: shared sprite-layer types and defaults for the layer mux / collision stage.
package layers_pkg;
    localparam int NUM_OBJ_DEF = 4;
    typedef logic [7:0] rgb332_t;
    localparam rgb332_t DEFAULT_RGB_DEF = 8'hFF;
    typedef enum logic {ARMED, FIRED} col_state_t;
endpackage

// File: rtl/collision_latch.sv
// collision_latch: one ARMED/FIRED collision channel with its per-frame hit accumulator bit.
module collision_latch
    import layers_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic i_hit,
    output logic o_pulse,
    output logic o_acc
);
    col_state_t r_state, w_next;
    logic       w_pulse;
    logic       r_pulse;
    logic       r_acc;
    // A hit in the startOfFrame cycle belongs to the new frame, so it fires straight away.
    always_comb begin
        w_next  = r_state;
        w_pulse = 1'b0;
        if (startOfFrame) begin
            w_next  = i_hit ? FIRED : ARMED;
            w_pulse = i_hit;
        end else if (r_state == ARMED && i_hit) begin
            w_next  = FIRED;
            w_pulse = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ARMED;
            r_pulse <= 1'b0;
            r_acc   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pulse <= w_pulse;
            r_acc   <= startOfFrame ? i_hit : (r_acc | i_hit);
        end
    end
    assign o_pulse = r_pulse;
    assign o_acc   = r_acc;
endmodule

// File: rtl/layers_mux_collision.sv
// layers_mux_collision: priority sprite-layer colour mux with player collision pulses
// and a per-frame collision mask published at each startOfFrame.
module layers_mux_collision
    import layers_pkg::*;
#(
    parameter int      NUM_OBJ     = NUM_OBJ_DEF,
    parameter rgb332_t DEFAULT_RGB = DEFAULT_RGB_DEF
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [NUM_OBJ-1:0]   objDrawReq,
    input  logic [8*NUM_OBJ-1:0] objRGB,
    input  logic [7:0]           bgRGB,
    input  logic                 boardersDrawReq,
    output logic [7:0]           RGBOut,
    output logic [NUM_OBJ-1:0]   colPulse,
    output logic [NUM_OBJ-1:0]   frameHitMask
);
    rgb332_t            w_rgb;
    logic [NUM_OBJ-1:0] w_hit;
    logic [NUM_OBJ-1:0] w_acc;
    // Walk from lowest priority upward so layer 0 wins last.
    always_comb begin
        w_rgb = bgRGB;
        for (int i = NUM_OBJ - 1; i >= 0; i--)
            if (objDrawReq[i]) w_rgb = objRGB[8*i +: 8];
    end
    assign w_hit = {objDrawReq[NUM_OBJ-1:1] & {(NUM_OBJ-1){objDrawReq[0]}},
                    objDrawReq[0] & boardersDrawReq};
    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_ch
        collision_latch u_latch (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .i_hit        (w_hit[g]),
            .o_pulse      (colPulse[g]),
            .o_acc        (w_acc[g])
        );
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBOut       <= DEFAULT_RGB;
            frameHitMask <= '0;
        end else begin
            RGBOut       <= w_rgb;
            frameHitMask <= startOfFrame ? w_acc : frameHitMask;
        end
    end
endmodule

// File: tb/tb_layers_mux_collision.sv
// tb_layers_mux_collision: scoreboard bench for the layer mux and collision channels.
module tb_layers_mux_collision;
    localparam int N = 4;
    typedef struct packed {
        logic [7:0]   rgb;
        logic [N-1:0] pulse;
        logic [N-1:0] mask;
    } exp_t;

    logic           clk = 1'b0;
    logic           resetN = 1'b0;
    logic           startOfFrame = 1'b0;
    logic [N-1:0]   objDrawReq = '0;
    logic [8*N-1:0] objRGB = '0;
    logic [7:0]     bgRGB = '0;
    logic           boardersDrawReq = 1'b0;
    logic [7:0]     RGBOut;
    logic [N-1:0]   colPulse;
    logic [N-1:0]   frameHitMask;

    exp_t         sb[$];
    logic [N-1:0] m_fired = '0;
    logic [N-1:0] m_acc = '0;
    logic [N-1:0] m_mask = '0;
    int           n_cmp = 0;
    int           n_bad = 0;

    layers_mux_collision #(.NUM_OBJ(N), .DEFAULT_RGB(8'hFF)) dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .objDrawReq      (objDrawReq),
        .objRGB          (objRGB),
        .bgRGB           (bgRGB),
        .boardersDrawReq (boardersDrawReq),
        .RGBOut          (RGBOut),
        .colPulse        (colPulse),
        .frameHitMask    (frameHitMask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel at the negedge, push the modelled result, then compare after the next posedge.
    task automatic step(input string tag, input logic sof, input logic [N-1:0] req,
                        input logic [8*N-1:0] rgbs, input logic [7:0] bg, input logic brd);
        exp_t         e;
        logic [N-1:0] h;
        logic         found;
        startOfFrame    = sof;
        objDrawReq      = req;
        objRGB          = rgbs;
        bgRGB           = bg;
        boardersDrawReq = brd;
        e.rgb = bg;
        found = 1'b0;
        for (int i = 0; i < N; i++)
            if (!found && req[i]) begin
                e.rgb = rgbs[8*i +: 8];
                found = 1'b1;
            end
        h[0] = req[0] & brd;
        for (int i = 1; i < N; i++) h[i] = req[0] & req[i];
        for (int i = 0; i < N; i++) begin
            e.pulse[i] = sof ? h[i] : (!m_fired[i] && h[i]);
            m_fired[i] = sof ? h[i] : (m_fired[i] | h[i]);
        end
        if (sof) m_mask = m_acc;
        m_acc = sof ? h : (m_acc | h);
        e.mask = m_mask;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rgb"}, 32'(RGBOut), 32'(e.rgb));
            chk({tag, "_pulse"}, 32'(colPulse), 32'(e.pulse));
            chk({tag, "_mask"}, 32'(frameHitMask), 32'(e.mask));
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        #1;
        chk("rst_rgb", 32'(RGBOut), 32'hFF);
        chk("rst_pulse", 32'(colPulse), 32'h0);
        chk("rst_mask", 32'(frameHitMask), 32'h0);
        m_fired = '0;
        m_acc   = '0;
        m_mask  = '0;
        sb.delete();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    localparam logic [8*N-1:0] RGBS = {8'h55, 8'h03, 8'hE0, 8'hAA};

    initial begin
        @(negedge clk);
        do_reset();
        step("sof0", 1, 4'b0000, RGBS, 8'h00, 0);
        step("bg", 0, 4'b0000, RGBS, 8'h1C, 0);
        step("obj12", 0, 4'b0110, RGBS, 8'h1C, 0);
        chk("obj12_rgb_const", 32'(RGBOut), 32'hE0);
        step("player_only", 0, 4'b0001, RGBS, 8'h1C, 0);
        step("obj3", 0, 4'b1000, RGBS, 8'h1C, 0);
        step("no_player_brd", 0, 4'b0110, RGBS, 8'h1C, 1);
        for (int k = 0; k < 5; k++) step("brd_hit", 0, 4'b0001, RGBS, 8'h1C, 1);
        step("sof_brd", 1, 4'b0000, RGBS, 8'h1C, 0);
        chk("brd_mask_const", 32'(frameHitMask), 32'h1);
        step("sof_clean", 1, 4'b0000, RGBS, 8'h1C, 0);
        step("sof_hit3", 1, 4'b1001, RGBS, 8'h1C, 0);
        chk("sof_hit3_pulse_const", 32'(colPulse), 32'h8);
        chk("sof_hit3_mask_const", 32'(frameHitMask), 32'h0);
        step("idle", 0, 4'b0000, RGBS, 8'h1C, 0);
        step("sof_pub3", 1, 4'b0000, RGBS, 8'h1C, 0);
        chk("pub3_mask_const", 32'(frameHitMask), 32'h8);
        step("hit12", 0, 4'b0111, RGBS, 8'h1C, 0);
        chk("hit12_pulse_const", 32'(colPulse), 32'h6);
        step("hit12_again", 0, 4'b0111, RGBS, 8'h1C, 0);
        step("hit2_pre_rst", 1, 4'b0101, RGBS, 8'h1C, 0);
        step("hit2_more", 0, 4'b0101, RGBS, 8'h1C, 0);
        do_reset();
        step("post_rst_idle", 0, 4'b0000, RGBS, 8'h1C, 0);
        step("post_rst_sof", 1, 4'b0000, RGBS, 8'h1C, 0);
        chk("post_rst_mask_const", 32'(frameHitMask), 32'h0);
        for (int k = 0; k < 60; k++)
            step("rand", ($urandom_range(0, 9) == 0), 4'($urandom), {$urandom},
                 8'($urandom), 1'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
